// File: rtl/rcu_seq_pkg.sv
// Shared constants for the reset control unit sequencer.
//   - register word addresses of the configuration map
//   - sequencer state encodings
//   - bit positions inside the STAT register
package rcu_seq_pkg;

   localparam logic [3:0] ADDR_CTRL = 4'd0;
   localparam logic [3:0] ADDR_DLY  = 4'd1;
   localparam logic [3:0] ADDR_STAT = 4'd2;
   localparam logic [3:0] ADDR_DIV0 = 4'd4;

   localparam logic [1:0] ST_ASSERT  = 2'd0;
   localparam logic [1:0] ST_RELEASE = 2'd1;
   localparam logic [1:0] ST_RUN     = 2'd2;

   localparam int STAT_BUSY = 0;
   localparam int STAT_EXT  = 1;
   localparam int STAT_WDT  = 2;
   localparam int STAT_POR  = 3;

endpackage

// File: rtl/rcu_cken_div.sv
// Per-channel clock-enable divider.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   run          : channel out of reset and enabled
//   div          : programmed divisor; a pulse every div+1 cycles
//   cken         : registered clock-enable pulse
// The divisor is only sampled when a period starts (wrap or restart), so
// reprogramming never truncates a period already in progress.
module rcu_cken_div
   import rcu_seq_pkg::*;
#(
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 run,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 cken
);

   // Down-counter: loaded with the divisor at period start, pulse at zero.
   // Equivalent to counting up from 0 to div and wrapping.
   logic [DIV_WIDTH-1:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         cken  <= 1'b0;
      end else if (!run) begin
         cnt_q <= div;
         cken  <= 1'b0;
      end else if (cnt_q == '0) begin
         cnt_q <= div;
         cken  <= 1'b1;
      end else begin
         cnt_q <= cnt_q - 1'b1;
         cken  <= 1'b0;
      end
   end

endmodule

// File: rtl/rcu_seq.sv
// Reset control unit sequencer.
// Holds all channel resets for ASSERT_CYC cycles, then releases channels one
// by one with a programmable gap, then generates per-channel clock enables.
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   cfg_we_i/addr/wdata  : single-cycle register write port
//   cfg_rdata_o          : combinational read data for cfg_addr_i
//   ext_rst_req_i        : external reset request (level)
//   wdt_rst_req_i        : watchdog reset request (level)
//   rst_n_o              : per-channel active-low resets
//   clk_en_o             : per-channel clock-enable pulses
//   seq_busy_o           : high while the sequence is not in RUN
//
// state      | meaning
// ST_ASSERT  | all channels in reset, counting the minimum assert time
// ST_RELEASE | releasing channel k after a DLY+1 cycle gap
// ST_RUN     | all channels released, waiting for a reset request
module rcu_seq
   import rcu_seq_pkg::*;
#(
   parameter int CH_NUM     = 4,
   parameter int DIV_WIDTH  = 8,
   parameter int DLY_WIDTH  = 8,
   parameter int ASSERT_CYC = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cfg_we_i,
   input  logic [3:0]        cfg_addr_i,
   input  logic [31:0]       cfg_wdata_i,
   output logic [31:0]       cfg_rdata_o,
   input  logic              ext_rst_req_i,
   input  logic              wdt_rst_req_i,
   output logic [CH_NUM-1:0] rst_n_o,
   output logic [CH_NUM-1:0] clk_en_o,
   output logic              seq_busy_o
);

   localparam int KW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int AW = (ASSERT_CYC > 1) ? $clog2(ASSERT_CYC) : 1;
   localparam int TW = (DLY_WIDTH > AW) ? DLY_WIDTH : AW;

   logic [CH_NUM-1:0]    en_q;
   logic [DLY_WIDTH-1:0] dly_q;
   logic [DIV_WIDTH-1:0] div_q [CH_NUM];
   logic                 cause_ext_q;
   logic                 cause_wdt_q;
   logic                 cause_por_q;

   logic [1:0]           state_q;
   logic [TW-1:0]        tmr_q;
   logic [KW-1:0]        k_q;
   logic [CH_NUM-1:0]    rst_n_q;
   logic                 busy_q;

   logic wr_ctrl;
   logic wr_dly;
   logic wr_stat;
   logic req;
   logic unused_wdata;

   assign wr_ctrl      = cfg_we_i && (cfg_addr_i == ADDR_CTRL);
   assign wr_dly       = cfg_we_i && (cfg_addr_i == ADDR_DLY);
   assign wr_stat      = cfg_we_i && (cfg_addr_i == ADDR_STAT);
   assign req          = ext_rst_req_i | wdt_rst_req_i;
   assign unused_wdata = ^cfg_wdata_i;

   // Configuration registers: cleared only by rst_i, never by requests.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         en_q  <= '0;
         dly_q <= '1;
         for (int i = 0; i < CH_NUM; i++) begin
            div_q[i] <= '0;
         end
      end else begin
         if (wr_ctrl) begin
            en_q <= cfg_wdata_i[CH_NUM-1:0];
         end
         if (wr_dly) begin
            dly_q <= cfg_wdata_i[DLY_WIDTH-1:0];
         end
         for (int i = 0; i < CH_NUM; i++) begin
            if (cfg_we_i && (cfg_addr_i == ADDR_DIV0 + 4'(i))) begin
               div_q[i] <= cfg_wdata_i[DIV_WIDTH-1:0];
            end
         end
      end
   end

   // Cause flags: a live request wins over a same-cycle write-1-to-clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cause_ext_q <= 1'b0;
         cause_wdt_q <= 1'b0;
         cause_por_q <= 1'b1;
      end else begin
         cause_ext_q <= ext_rst_req_i | (cause_ext_q & ~(wr_stat & cfg_wdata_i[STAT_EXT]));
         cause_wdt_q <= wdt_rst_req_i | (cause_wdt_q & ~(wr_stat & cfg_wdata_i[STAT_WDT]));
         cause_por_q <= cause_por_q & ~(wr_stat & cfg_wdata_i[STAT_POR]);
      end
   end

   always_comb begin
      cfg_rdata_o = '0;
      case (cfg_addr_i)
         ADDR_CTRL: cfg_rdata_o[CH_NUM-1:0] = en_q;
         ADDR_DLY:  cfg_rdata_o[DLY_WIDTH-1:0] = dly_q;
         ADDR_STAT: begin
            cfg_rdata_o[STAT_BUSY] = busy_q;
            cfg_rdata_o[STAT_EXT]  = cause_ext_q;
            cfg_rdata_o[STAT_WDT]  = cause_wdt_q;
            cfg_rdata_o[STAT_POR]  = cause_por_q;
         end
         default: begin
            for (int i = 0; i < CH_NUM; i++) begin
               if (cfg_addr_i == ADDR_DIV0 + 4'(i)) begin
                  cfg_rdata_o[DIV_WIDTH-1:0] = div_q[i];
               end
            end
         end
      endcase
   end

   // Sequencer. tmr_q is a down-counter; a phase ends on the cycle it is 0,
   // so loading N-1 gives an N-cycle phase (DLY loaded gives DLY+1).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_ASSERT;
         tmr_q   <= TW'(ASSERT_CYC - 1);
         k_q     <= '0;
         rst_n_q <= '0;
         busy_q  <= 1'b1;
      end else if (req) begin
         state_q <= ST_ASSERT;
         tmr_q   <= TW'(ASSERT_CYC - 1);
         k_q     <= '0;
         rst_n_q <= '0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               if (tmr_q == '0) begin
                  state_q <= ST_RELEASE;
                  tmr_q   <= TW'(dly_q);
                  k_q     <= '0;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            ST_RELEASE: begin
               if (tmr_q == '0) begin
                  rst_n_q[k_q] <= 1'b1;
                  if (k_q == KW'(CH_NUM - 1)) begin
                     state_q <= ST_RUN;
                     busy_q  <= 1'b0;
                  end else begin
                     k_q   <= k_q + 1'b1;
                     tmr_q <= TW'(dly_q);
                  end
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            ST_RUN: begin
               busy_q <= 1'b0;
            end
            default: begin
               state_q <= ST_ASSERT;
               tmr_q   <= TW'(ASSERT_CYC - 1);
               k_q     <= '0;
               rst_n_q <= '0;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   assign rst_n_o    = rst_n_q;
   assign seq_busy_o = busy_q;

   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      rcu_cken_div #(
         .DIV_WIDTH (DIV_WIDTH)
      ) u_cken_div (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .run   (rst_n_q[i] & en_q[i]),
         .div   (div_q[i]),
         .cken  (clk_en_o[i])
      );
   end

endmodule
